// File: rtl/tm_spike_rate_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : tm_spike_rate_decoder_if
// Brief    : Rate-word stream (valid/ready) from the spike rate decoder.
// Revision : 1.0 - initial release
// ============================================================================
interface tm_spike_rate_decoder_if #(
  parameter int CNT_W = 8
);
  logic [CNT_W-1:0] rate;
  logic [2:0]       rate_ch;
  logic             rate_valid;
  logic             rate_ready;
  logic             frame_done;

  modport master (
    output rate,
    output rate_ch,
    output rate_valid,
    output frame_done,
    input  rate_ready
  );

  modport slave (
    input  rate,
    input  rate_ch,
    input  rate_valid,
    input  frame_done,
    output rate_ready
  );
endinterface
`default_nettype wire

// File: rtl/tm_spike_rate_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tm_spike_rate_decoder
// Brief    : Windowed per-channel spike counter streaming 8 rate words per
//            window; LEAKY_RATE_EN carries half of each count into the next.
// Revision : 1.0 - initial release
// ============================================================================
module tm_spike_rate_decoder #(
  parameter int WINDOW = 255,
  parameter int CNT_W  = 8
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic       en_i,
  input  wire logic [7:0] spike_i,
  input  wire logic       clr_ovr_i,
  output logic            overrun_o,
  tm_spike_rate_decoder_if.master rate_if
);

  localparam int                 c_win_w    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [c_win_w-1:0] c_win_last = c_win_w'(WINDOW - 1);
  localparam logic [CNT_W-1:0]   c_cnt_max  = '1;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [c_win_w-1:0]      win_q, win_d;
  logic [2:0]              ch_q, ch_d;
  logic                    fd_q, fd_d;
  logic                    ovr_q, ovr_d;
  logic [7:0][CNT_W-1:0]   shadow_q;
  logic [7:0][CNT_W-1:0]   w_snap;
  logic                    w_wend;
  logic                    w_xfer;
  logic                    w_load;

  assign w_wend = en_i && (win_q == c_win_last);
  assign w_xfer = (state_q == S_DRAIN) && rate_if.rate_ready;

  always_comb begin
    win_d = win_q;
    if (en_i) begin
      win_d = w_wend ? '0 : win_q + c_win_w'(1);
    end
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_chan
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   w_sum;

    assign w_sum      = {1'b0, cnt_q} + {{CNT_W{1'b0}}, spike_i[gi]};
    assign w_snap[gi] = w_sum[CNT_W] ? c_cnt_max : w_sum[CNT_W-1:0];

    always_comb begin
      cnt_d = cnt_q;
      if (en_i) begin
        if (w_wend) begin
`ifdef LEAKY_RATE_EN
          cnt_d = w_snap[gi] >> 1;
`else
          cnt_d = '0;
`endif
        end else begin
          cnt_d = w_snap[gi];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  // A window ending on the channel-7 transfer reloads the shadow bank
  // immediately, so the stream restarts without a bubble or an overrun.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    fd_d    = 1'b0;
    ovr_d   = ovr_q;
    w_load  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_wend) begin
          w_load  = 1'b1;
          state_d = S_DRAIN;
          ch_d    = 3'd0;
        end
      end
      S_DRAIN: begin
        if (w_xfer) begin
          if (ch_q == 3'd7) begin
            ch_d = 3'd0;
            fd_d = 1'b1;
            if (w_wend) begin
              w_load = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            ch_d = ch_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        ch_d    = 3'd0;
      end
    endcase
    if (w_wend && !w_load) begin
      ovr_d = 1'b1;
    end else if (clr_ovr_i) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      win_q    <= '0;
      ch_q     <= 3'd0;
      fd_q     <= 1'b0;
      ovr_q    <= 1'b0;
      shadow_q <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      ch_q    <= ch_d;
      fd_q    <= fd_d;
      ovr_q   <= ovr_d;
      if (w_load) begin
        shadow_q <= w_snap;
      end
    end
  end

  assign rate_if.rate       = shadow_q[ch_q];
  assign rate_if.rate_ch    = ch_q;
  assign rate_if.rate_valid = (state_q == S_DRAIN);
  assign rate_if.frame_done = fd_q;
  assign overrun_o          = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_tm_spike_rate_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_tm_spike_rate_decoder
// Brief    : Two decoder instances (4/8 and 32/4) against a window-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tm_spike_rate_decoder;
  localparam int WA = 4;
  localparam int CA = 8;
  localparam int WB = 32;
  localparam int CB = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic       clr   = 1'b0;
  logic       rdy_a = 1'b0;
  logic       rdy_b = 1'b0;
  logic [7:0] spike = 8'h00;
  logic       ovr_a, ovr_b;

  tm_spike_rate_decoder_if #(.CNT_W(CA)) if_a ();
  tm_spike_rate_decoder_if #(.CNT_W(CB)) if_b ();
  assign if_a.rate_ready = rdy_a;
  assign if_b.rate_ready = rdy_b;

  tm_spike_rate_decoder #(.WINDOW(WA), .CNT_W(CA)) dut_a (
    .clk(clk), .rst_n(rst_n), .en_i(en), .spike_i(spike), .clr_ovr_i(clr),
    .overrun_o(ovr_a), .rate_if(if_a.master));
  tm_spike_rate_decoder #(.WINDOW(WB), .CNT_W(CB)) dut_b (
    .clk(clk), .rst_n(rst_n), .en_i(en), .spike_i(spike), .clr_ovr_i(clr),
    .overrun_o(ovr_b), .rate_if(if_b.master));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- window-level reference model ----------------
  int WINv[2] = '{WA, WB};
  int MAXv[2] = '{(1 << CA) - 1, (1 << CB) - 1};
  int m_win[2];
  int m_acc[2][8];
  int m_frame[2][8];
  int m_busy[2];
  int m_ch[2];
  int m_fd[2];
  int m_ovr[2];
  int qa[$];
  int qb[$];

  task automatic model_step(input int k, input logic rdy);
    int  snap[8];
    bit  wend, blocked;
    wend = en && (m_win[k] == WINv[k] - 1);
    for (int i = 0; i < 8; i++) begin
      snap[i] = m_acc[k][i] + int'(spike[i]);
      if (snap[i] > MAXv[k]) snap[i] = MAXv[k];
    end
    m_fd[k] = 0;
    if (m_busy[k] != 0 && rdy) begin
      if (m_ch[k] == 7) begin
        m_busy[k] = 0;
        m_ch[k]   = 0;
        m_fd[k]   = 1;
      end else begin
        m_ch[k]++;
      end
    end
    blocked = wend && (m_busy[k] != 0);
    if (wend && !blocked) begin
      for (int i = 0; i < 8; i++) m_frame[k][i] = snap[i];
      m_busy[k] = 1;
      m_ch[k]   = 0;
    end
    if (blocked) m_ovr[k] = 1;
    else if (clr) m_ovr[k] = 0;
    if (en) begin
      for (int i = 0; i < 8; i++) begin
`ifdef LEAKY_RATE_EN
        m_acc[k][i] = wend ? snap[i] / 2 : snap[i];
`else
        m_acc[k][i] = wend ? 0 : snap[i];
`endif
      end
      m_win[k] = wend ? 0 : m_win[k] + 1;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_win[k] = 0; m_busy[k] = 0; m_ch[k] = 0; m_fd[k] = 0; m_ovr[k] = 0;
        for (int i = 0; i < 8; i++) begin
          m_acc[k][i] = 0;
          m_frame[k][i] = 0;
        end
      end
    end else begin
      if (if_a.rate_valid && rdy_a) qa.push_back(int'(if_a.rate));
      if (if_b.rate_valid && rdy_b) qb.push_back(int'(if_b.rate));
      model_step(0, rdy_a);
      model_step(1, rdy_b);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int v, c, r, fd, ov;
      v  = (k == 0) ? int'(if_a.rate_valid) : int'(if_b.rate_valid);
      c  = (k == 0) ? int'(if_a.rate_ch)    : int'(if_b.rate_ch);
      r  = (k == 0) ? int'(if_a.rate)       : int'(if_b.rate);
      fd = (k == 0) ? int'(if_a.frame_done) : int'(if_b.frame_done);
      ov = (k == 0) ? int'(ovr_a)           : int'(ovr_b);
      chk($sformatf("dut%0d rate_valid", k), v, m_busy[k]);
      chk($sformatf("dut%0d rate_ch", k), c, m_ch[k]);
      chk($sformatf("dut%0d frame_done", k), fd, m_fd[k]);
      chk($sformatf("dut%0d overrun", k), ov, m_ovr[k]);
      if (m_busy[k] != 0) chk($sformatf("dut%0d rate", k), r, m_frame[k][m_ch[k]]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic e, input logic [7:0] s, input logic ra,
                     input logic rb, input logic cl = 1'b0);
    en = e; spike = s; rdy_a = ra; rdy_b = rb; clr = cl;
    @(negedge clk);
  endtask

  // Asserted mid-cycle; outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst rate_a", int'(if_a.rate), 0);
    chk("rst ch_a", int'(if_a.rate_ch), 0);
    chk("rst valid_a", int'(if_a.rate_valid), 0);
    chk("rst fd_a", int'(if_a.frame_done), 0);
    chk("rst ovr_a", int'(ovr_a), 0);
    chk("rst valid_b", int'(if_b.rate_valid), 0);
    chk("rst ovr_b", int'(ovr_b), 0);
    en = 1'b0; spike = 8'h00; rdy_a = 1'b0; rdy_b = 1'b0; clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    qa.delete();
    qb.delete();
  endtask

  function automatic logic [7:0] pat(input int c);
    return (c == 2) ? 8'h81 : 8'h01;
  endfunction

  task automatic chk_frame1(input string nm);
    int exp[8] = '{4, 0, 0, 0, 0, 0, 0, 1};
    if (qa.size() < 8) chk({nm, " word count"}, qa.size(), 8);
    else for (int i = 0; i < 8; i++) chk($sformatf("%s ch%0d", nm, i), qa[i], exp[i]);
  endtask

  initial begin
    int ch1_exp[4];
`ifdef LEAKY_RATE_EN
    ch1_exp = '{4, 6, 7, 7};
`else
    ch1_exp = '{4, 4, 4, 4};
`endif
    // 1. reset, then idle with en=0
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
      chk("idle valid_a", int'(if_a.rate_valid), 0);
    end

    // 2. basic frame, latency, and wend coinciding with the ch7 transfer
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      cyc(1'b1, pat(c), 1'b1, 1'b1);
      if (c == 3) chk("latency pre valid", int'(if_a.rate_valid), 0);
    end
    chk("latency valid", int'(if_a.rate_valid), 1);
    chk("latency rate", int'(if_a.rate), 4);
    for (int c = 0; c < 4; c++) cyc(1'b0, 8'h00, 1'b1, 1'b1);
    for (int c = 0; c < 4; c++) cyc(1'b1, 8'h01, 1'b1, 1'b1);
    chk("same-cycle ovr", int'(ovr_a), 0);
    chk("same-cycle valid", int'(if_a.rate_valid), 1);
    chk("same-cycle ch", int'(if_a.rate_ch), 0);
    chk("same-cycle frame_done", int'(if_a.frame_done), 1);
    chk_frame1("basic");

    // 3. backpressure at ch2
    do_reset();
    for (int c = 1; c <= 4; c++) cyc(1'b1, pat(c), 1'b1, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      chk("stall valid", int'(if_a.rate_valid), 1);
      chk("stall ch", int'(if_a.rate_ch), 2);
      chk("stall rate", int'(if_a.rate), 0);
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    chk("resume ch", int'(if_a.rate_ch), 3);
    for (int c = 0; c < 5; c++) cyc(1'b0, 8'h00, 1'b1, 1'b1);
    chk_frame1("backpressure");

    // 4. saturation on the 32-cycle, 4-bit instance
    do_reset();
    for (int c = 0; c < 32; c++) cyc(1'b1, 8'hFF, 1'b1, 1'b1);
    for (int c = 0; c < 10; c++) cyc(1'b0, 8'h00, 1'b1, 1'b1);
    if (qb.size() < 8) chk("sat word count", qb.size(), 8);
    else for (int i = 0; i < 8; i++) chk($sformatf("sat ch%0d", i), qb[i], 15);

    // 5. overrun keeps the first frame; clear afterwards
    do_reset();
    for (int c = 1; c <= 10; c++) begin
      cyc(1'b1, pat(c), 1'b0, 1'b0);
      if (c == 7) chk("ovr before 2nd wend", int'(ovr_a), 0);
      if (c == 8) chk("ovr after 2nd wend", int'(ovr_a), 1);
    end
    for (int c = 0; c < 8; c++) cyc(1'b0, 8'h00, 1'b1, 1'b1);
    chk_frame1("overrun");
    cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    chk("ovr cleared", int'(ovr_a), 0);

    // 6. en gating and leaky accumulation
    do_reset();
    for (int c = 0; c < 40; c++) cyc(c % 2 == 0, 8'h02, 1'b1, 1'b1);
    if (qa.size() < 32) chk("gating word count", qa.size(), 32);
    else for (int w = 0; w < 4; w++) chk($sformatf("gating win%0d ch1", w), qa[8*w+1], ch1_exp[w]);

    // randomized traffic
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      int pr;
      pr = 2 + 2 * (n / 1000);
      cyc($urandom_range(0, 9) < 8, 8'($urandom),
          $urandom_range(0, 9) < pr, $urandom_range(0, 9) < pr,
          $urandom_range(0, 19) == 0);
    end
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1'b0, 8'h00, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/tm_spike_rate_decoder.md
Name: tm_spike_rate_decoder

Overview:
- Spike-to-value decoder on the output side of the time-multiplexed LIF neuron array. It turns the 8-bit parallel spike vector back into per-neuron rate words.
- Counts spikes per channel over a fixed window of enabled cycles.
- At each window end, snapshots the 8 counts into a shadow bank.
- Streams the shadow bank out one channel per handshake on a valid/ready port, channel 0 first. Counting of the next window continues in parallel.

Parameters:
WINDOW, 255, enabled cycles per counting window (legal range 2..65535)
CNT_W, 8, width of each per-channel spike counter and rate word (4..16)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  count enable; window counter and spike counters advance only when 1
spike  in  8  spike vector, bit i = neuron i fired this cycle
rate  out  CNT_W  rate word of channel rate_ch
rate_ch  out  3  channel index of current rate word
rate_valid  out  1  rate/rate_ch valid
rate_ready  in  1  downstream accepts when rate_valid & rate_ready
frame_done  out  1  one-cycle pulse after channel 7 transferred
overrun  out  1  sticky: window ended while previous frame still draining
clr_ovr  in  1  synchronous clear of overrun

Behaviour:
- Reset (async, rst_n=0):
  - All outputs go to 0: rate=0, rate_ch=0, rate_valid=0, frame_done=0, overrun=0.
  - Window counter = 0, all counters = 0, shadow bank = 0, FSM = IDLE.
  - Reset mid-drain abandons the frame and does not set overrun.
- Window counter:
  - Counts 0..WINDOW-1 on cycles with en=1; holds when en=0.
  - The window end (wend) is the cycle with en=1 and count==WINDOW-1. The counter wraps to 0 on the next edge.
- Spike counters (8 x CNT_W):
  - When en=1, cnt[i] += spike[i], saturating at 2^CNT_W-1 (no wrap).
  - When en=0, spikes are ignored and counters hold.
  - On wend, the value including that cycle's spike, snap[i] = sat(cnt[i]+spike[i]), is the window result. Counters then restart at 0.
- FSM states: IDLE, DRAIN.
  - IDLE: rate_valid=0. On wend, load shadow[i]=snap[i]; next cycle enter DRAIN with rate_ch=0 and rate_valid=1.
  - DRAIN: rate = shadow[rate_ch]. rate, rate_ch and rate_valid must stay stable until accepted.
  - On a transfer with rate_ch<7, rate_ch increments next cycle.
  - On a transfer with rate_ch==7: rate_valid goes to 0 and rate_ch goes to 0 next cycle; frame_done=1 for exactly that next cycle; FSM returns to IDLE.
- wend during DRAIN, drain not finishing this cycle:
  - New snapshot is dropped and the shadow bank is untouched.
  - overrun is set to 1 next cycle.
  - Counters still restart at 0.
- wend in the same cycle as the channel-7 transfer:
  - Treated as free: shadow is loaded and no overrun.
  - Next cycle the FSM re-enters DRAIN (rate_valid=1, ch 0) and frame_done=1 in that same cycle.
- overrun:
  - Cleared by clr_ovr=1 on the next edge.
  - Set has priority over clear in the same cycle.
- Latency: wend cycle N -> rate_valid=1 with ch0 at cycle N+1. Minimum drain is 8 cycles with rate_ready held at 1.
- Handshake independence: en has no effect on draining; the handshake proceeds with en=0.

Optional Feature:
- Macro: LEAKY_RATE_EN.
- Defined: at wend, counters are not cleared. They load snap[i]>>1, matching the neuron leak, so the rate word is an exponentially weighted average across windows. Saturation is unchanged.
- Undefined: counters clear to 0 at wend (pure windowed count).

Test Plan:
1. Reset: drive rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately. Release, en=0 for 20 cycles -> rate_valid stays 0.
2. WINDOW=4, CNT_W=8, en=1, spike=8'h01 every cycle, spike=8'h80 on the 2nd cycle only, rate_ready=1:
   - rate_valid rises 1 cycle after the 4th cycle.
   - Words ch0..7 = 4,0,0,0,0,0,0,1 on consecutive cycles.
   - frame_done pulses once after ch7.
3. Backpressure: same stimulus, rate_ready=0 for 3 cycles at ch2 -> rate=0, rate_ch=2 held stable; resumes with ch3 after ready=1.
4. Saturation: CNT_W=4, WINDOW=32, spike=8'hFF constant -> every word = 15.
5. Overrun: WINDOW=4, rate_ready=0 for 10 cycles:
   - overrun=1 the cycle after the 2nd wend; first frame data is unchanged when drained.
   - clr_ovr pulse -> overrun=0.
   - Then the same-cycle case: ready timed so ch7 transfers on a wend cycle -> overrun stays 0, rate_valid stays 1 and restarts at ch0.
6. en gating: WINDOW=4, en toggled 1,0,1,0,... with spike=8'h02 -> wend after 8 cycles; ch1 word = 4.
   - With LEAKY_RATE_EN defined and the same constant input over successive windows: ch1 words are 4, 6, 7, 7.
